// File: rtl/sort_n_pipe.sv
// Pipelined odd-even transposition sorter: N registered compare-exchange stages,
// valid/ready handshake with whole-pipeline stall, per-vector direction and min/median/max taps.
module sort_n_pipe #(
  parameter int N          = 5,
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_descend,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] sorted_data,
  output logic [DATA_WIDTH-1:0]   min_out,
  output logic [DATA_WIDTH-1:0]   max_out,
  output logic [DATA_WIDTH-1:0]   median_out
);

  logic                  ce;
  logic [N-1:0]          valid_q;
  logic [N-1:0]          desc_q;
  logic [DATA_WIDTH-1:0] data_q  [N][N];
  logic [DATA_WIDTH-1:0] stage_x [N][N];
  logic [DATA_WIDTH-1:0] stage_d [N][N];
  logic [N-1:0]          stage_desc;

  // True when the pair (a above b) must be exchanged for the requested order.
  function automatic logic do_swap(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic                  desc);
    logic gt;
    logic lt;
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  assign ce       = !valid_q[N-1] || out_ready;
  assign in_ready = ce;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      localparam int P = gi % 2;

      if (gi == 0) begin : g_src_in
        assign stage_desc[gi] = in_descend;
        for (gj = 0; gj < N; gj++) begin : g_unpack
          assign stage_x[gi][gj] = in_data[(N-gj)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
      end else begin : g_src_prev
        assign stage_desc[gi] = desc_q[gi-1];
        for (gj = 0; gj < N; gj++) begin : g_fwd
          assign stage_x[gi][gj] = data_q[gi-1][gj];
        end
      end

      for (gj = 0; gj < N; gj++) begin : g_elem
        if ((gj >= P) && (((gj - P) % 2) == 0) && (gj + 1 < N)) begin : g_lo
          assign stage_d[gi][gj] = do_swap(stage_x[gi][gj], stage_x[gi][gj+1], stage_desc[gi])
                                   ? stage_x[gi][gj+1] : stage_x[gi][gj];
        end else if ((gj >= P + 1) && (((gj - 1 - P) % 2) == 0)) begin : g_hi
          assign stage_d[gi][gj] = do_swap(stage_x[gi][gj-1], stage_x[gi][gj], stage_desc[gi])
                                   ? stage_x[gi][gj-1] : stage_x[gi][gj];
        end else begin : g_pass
          assign stage_d[gi][gj] = stage_x[gi][gj];
        end
      end
    end

    for (gj = 0; gj < N; gj++) begin : g_pack
      assign sorted_data[(N-gj)*DATA_WIDTH-1 -: DATA_WIDTH] = data_q[N-1][gj];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      desc_q  <= '0;
      for (int s = 0; s < N; s++) begin
        for (int e = 0; e < N; e++) begin
          data_q[s][e] <= '0;
        end
      end
    end else if (ce) begin
      valid_q <= {valid_q[N-2:0], in_valid};
      desc_q  <= stage_desc;
      for (int s = 0; s < N; s++) begin
        for (int e = 0; e < N; e++) begin
          data_q[s][e] <= stage_d[s][e];
        end
      end
    end
  end

  // Ends of the last stage swap roles with the vector's direction.
  assign out_valid  = valid_q[N-1];
  assign min_out    = desc_q[N-1] ? data_q[N-1][N-1] : data_q[N-1][0];
  assign max_out    = desc_q[N-1] ? data_q[N-1][0]   : data_q[N-1][N-1];
  assign median_out = data_q[N-1][(N-1)/2];

endmodule

// File: tb/tb_sort_n_pipe.sv
// Directed bench for sort_n_pipe: unsigned N=5, signed N=5 and unsigned N=4 builds
// driven side by side, with a random backpressure run checked against a sorting model.
module tb_sort_n_pipe;

  localparam int N = 5;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_descend;
  logic          out_ready;
  logic [N*W-1:0] in_data;
  logic [4*W-1:0] in_data4;

  logic           in_ready, out_valid;
  logic [N*W-1:0] sorted_data;
  logic [W-1:0]   min_out, max_out, median_out;

  logic           s_in_ready, s_out_valid;
  logic [N*W-1:0] s_sorted;
  logic [W-1:0]   s_min, s_max, s_med;

  logic           f_in_ready, f_out_valid;
  logic [4*W-1:0] f_sorted;
  logic [W-1:0]   f_min, f_max, f_med;

  int tests = 0;
  int fails = 0;

  logic [63:0]    cap;
  logic           cap_valid;
  logic [N*W-1:0] cap_s;
  logic [4*W-1:0] cap4_sorted;
  logic [W-1:0]   cap4_med;

  always #5 clk = ~clk;

  sort_n_pipe #(.N(5), .DATA_WIDTH(8), .SIGNED(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_descend(in_descend), .out_valid(out_valid),
    .out_ready(out_ready), .sorted_data(sorted_data), .min_out(min_out),
    .max_out(max_out), .median_out(median_out));

  sort_n_pipe #(.N(5), .DATA_WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_descend(in_descend), .out_valid(s_out_valid),
    .out_ready(out_ready), .sorted_data(s_sorted), .min_out(s_min),
    .max_out(s_max), .median_out(s_med));

  sort_n_pipe #(.N(4), .DATA_WIDTH(8), .SIGNED(1'b0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_data(in_data4), .in_descend(in_descend), .out_valid(f_out_valid),
    .out_ready(out_ready), .sorted_data(f_sorted), .min_out(f_min),
    .max_out(f_max), .median_out(f_med));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pk5(input logic [7:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  // Reference: bubble sort ascending, then read out in the requested order.
  function automatic logic [63:0] ref_sort(input logic [39:0] d, input logic desc);
    logic [7:0]  a [5];
    logic [7:0]  t;
    logic [39:0] s;
    for (int i = 0; i < 5; i++) a[i] = d[(5-i)*8-1 -: 8];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    s = '0;
    for (int i = 0; i < 5; i++) s[(5-i)*8-1 -: 8] = desc ? a[4-i] : a[i];
    return {s, a[0], a[4], a[2]};
  endfunction

  // One vector through an idle pipeline with out_ready held high; latency checked.
  task automatic run_vec(input logic [39:0] d, input logic [31:0] d4, input logic desc);
    @(negedge clk);
    in_data = d; in_data4 = d4; in_descend = desc; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= N; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (c == N - 1) begin
        chk("latency_early", 64'(out_valid), 64'd0);
        chk("n4_valid", 64'(f_out_valid), 64'd1);
        cap4_sorted = f_sorted;
        cap4_med    = f_med;
      end
      if (c == N) begin
        cap_valid = out_valid;
        cap       = {sorted_data, min_out, max_out, median_out};
        cap_s     = s_sorted;
      end
    end
    $display("[TB] vec in=%h desc=%0d -> valid=%0d out=%h", d, desc, cap_valid, cap);
  endtask

  initial begin
    logic [39:0]  cur_d;
    logic         cur_desc;
    logic [63:0]  obs, held;
    logic [63:0]  q[$];
    int           sent, rcvd, cyc, seen;
    bit           pending, prev_stall;

    rst = 1'b1; in_valid = 1'b0; in_descend = 1'b0; out_ready = 1'b1;
    in_data = '0; in_data4 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", {sorted_data, min_out, max_out, median_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_vec(pk5(9, 3, 7, 1, 5), 32'd0, 1'b0);
    chk("asc_valid", 64'(cap_valid), 64'd1);
    chk("asc", cap, {pk5(1, 3, 5, 7, 9), 8'd1, 8'd9, 8'd5});

    run_vec(pk5(9, 3, 7, 1, 5), 32'd0, 1'b1);
    chk("desc_valid", 64'(cap_valid), 64'd1);
    chk("desc", cap, {pk5(9, 7, 5, 3, 1), 8'd1, 8'd9, 8'd5});

    run_vec(pk5(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01), 32'd0, 1'b0);
    chk("signed_sort", 64'(cap_s), 64'(pk5(8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F)));
    chk("unsigned_sort", 64'(cap[63:24]), 64'(pk5(8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF)));

    run_vec(pk5(4, 4, 2, 4, 2), {8'd8, 8'd6, 8'd2, 8'd4}, 1'b0);
    chk("dups", cap, {pk5(2, 2, 4, 4, 4), 8'd2, 8'd4, 8'd4});
    chk("n4_sorted", 64'(cap4_sorted), 64'({8'd2, 8'd4, 8'd6, 8'd8}));
    chk("n4_median", 64'(cap4_med), 64'd4);

    // Random backpressure run with scoreboard and stall-hold checks.
    sent = 0; rcvd = 0; cyc = 0; pending = 0; prev_stall = 0;
    cur_d = '0; cur_desc = 1'b0; held = '0;
    while (rcvd < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (!pending && sent < 20) begin
        for (int e = 0; e < N; e++) cur_d[e*8 +: 8] = 8'($urandom);
        cur_desc = sent[0];
        pending  = 1'b1;
      end
      in_valid = pending; in_data = cur_d; in_descend = cur_desc;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      obs = {sorted_data, min_out, max_out, median_out};
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", obs, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 64'(q.size()), 64'd1);
        else begin
          chk("rand_vec", obs, q.pop_front());
          $display("[TB] rand out #%0d = %h", rcvd, obs);
          rcvd++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = obs;
      if (pending && in_ready) begin
        q.push_back(ref_sort(cur_d, cur_desc));
        $display("[TB] rand in #%0d = %h desc=%0d", sent, cur_d, cur_desc);
        pending = 1'b0;
        sent++;
      end
    end
    chk("rand_count", 64'(rcvd), 64'd20);

    // Reset with three vectors in flight, the oldest stalled at the output.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 1) @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = pk5(8'(k + 1), 8'd50, 8'd40, 8'd30, 8'd20); in_descend = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 10) begin
      @(negedge clk);
      seen++;
    end
    #1 chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (N + 3) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("rst_discard", 64'(seen), 64'd0);
    $display("[TB] reset with 3 in flight, vectors seen afterwards=%0d", seen);

    run_vec(pk5(200, 10, 150, 90, 60), 32'd0, 1'b1);
    chk("post_rst", cap, {pk5(200, 150, 90, 60, 10), 8'd10, 8'd200, 8'd90});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
